pipe_comp: RTL and testbench

PIPE_COMP -- requirements
Module: pipe_comp

---
 rtl/pipe_comp_pkg.sv | 14 +
 rtl/pipe_comp_core.sv | 32 +++
 rtl/pipe_comp.sv | 156 +++++++++++++++
 tb/tb_pipe_comp.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_comp_pkg.sv
// Shared result encoding and default sizing for the pipe_comp comparator.
// The optional min/max tracker in pipe_comp is enabled by defining PIPE_COMP_MINMAX_EN.
package pipe_comp_pkg;

  localparam int DATAWIDTH_DEF = 8;
  localparam int CNTWIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_e;

endpackage

// File: rtl/pipe_comp_core.sv
// Combinational magnitude comparator; signed mode flips the sign bits so a
// single unsigned compare serves both encodings.
module comp_core
  import pipe_comp_pkg::*;
#(
  parameter int W = DATAWIDTH_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sgn,
  output cmp_e         res
);

  logic [W-1:0] a_x_s;
  logic [W-1:0] b_x_s;

  // Bias operands into unsigned order, then classify.
  always_comb begin
    a_x_s        = a;
    b_x_s        = b;
    a_x_s[W-1]   = a[W-1] ^ sgn;
    b_x_s[W-1]   = b[W-1] ^ sgn;
    if (a_x_s == b_x_s) begin
      res = CMP_EQ;
    end else if (a_x_s < b_x_s) begin
      res = CMP_LT;
    end else begin
      res = CMP_GT;
    end
  end

endmodule

// File: rtl/pipe_comp.sv
// Latency-1 comparator with a single-entry output register, saturating result
// counters and, with PIPE_COMP_MINMAX_EN defined, a running max/min tracker of a.
module pipe_comp
  import pipe_comp_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int CNTWIDTH  = CNTWIDTH_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 gt,
  output logic                 lt,
  output logic                 eq,
`ifdef PIPE_COMP_MINMAX_EN
  output logic [DATAWIDTH-1:0] max_a,
  output logic [DATAWIDTH-1:0] min_a,
  output logic                 trk_vld,
`endif
  output logic [CNTWIDTH-1:0]  cnt_gt,
  output logic [CNTWIDTH-1:0]  cnt_lt,
  output logic [CNTWIDTH-1:0]  cnt_eq
);

  function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v, input logic inc);
    if (inc && (v != {CNTWIDTH{1'b1}})) begin
      sat_inc = v + CNTWIDTH'(1);
    end else begin
      sat_inc = v;
    end
  endfunction

  cmp_e                core_res_s;
  logic                acc_s;
  logic                out_valid_q, out_valid_d;
  logic                gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [CNTWIDTH-1:0] cnt_gt_q, cnt_gt_d, cnt_lt_q, cnt_lt_d, cnt_eq_q, cnt_eq_d;

  comp_core #(.W(DATAWIDTH)) u_core (.a(a), .b(b), .sgn(sgn), .res(core_res_s));

  assign in_ready  = !out_valid_q || out_ready;
  assign acc_s     = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign cnt_gt    = cnt_gt_q;
  assign cnt_lt    = cnt_lt_q;
  assign cnt_eq    = cnt_eq_q;

  // Output register: load on accept, empty on consume, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    if (acc_s) begin
      out_valid_d = 1'b1;
      gt_d        = (core_res_s == CMP_GT);
      lt_d        = (core_res_s == CMP_LT);
      eq_d        = (core_res_s == CMP_EQ);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      gt_d        = 1'b0;
      lt_d        = 1'b0;
      eq_d        = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Counters: clr zeroes first so a coincident accept still counts once.
  always_comb begin
    cnt_gt_d = sat_inc(clr ? {CNTWIDTH{1'b0}} : cnt_gt_q, acc_s && (core_res_s == CMP_GT));
    cnt_lt_d = sat_inc(clr ? {CNTWIDTH{1'b0}} : cnt_lt_q, acc_s && (core_res_s == CMP_LT));
    cnt_eq_d = sat_inc(clr ? {CNTWIDTH{1'b0}} : cnt_eq_q, acc_s && (core_res_s == CMP_EQ));
  end

  // Result and counter state.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      cnt_gt_q    <= {CNTWIDTH{1'b0}};
      cnt_lt_q    <= {CNTWIDTH{1'b0}};
      cnt_eq_q    <= {CNTWIDTH{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      cnt_gt_q    <= cnt_gt_d;
      cnt_lt_q    <= cnt_lt_d;
      cnt_eq_q    <= cnt_eq_d;
    end
  end

`ifdef PIPE_COMP_MINMAX_EN
  cmp_e                 vs_max_s, vs_min_s;
  logic [DATAWIDTH-1:0] max_a_q, max_a_d, min_a_q, min_a_d;
  logic                 trk_vld_q, trk_vld_d;

  comp_core #(.W(DATAWIDTH)) u_core_max (.a(a), .b(max_a_q), .sgn(sgn), .res(vs_max_s));
  comp_core #(.W(DATAWIDTH)) u_core_min (.a(a), .b(min_a_q), .sgn(sgn), .res(vs_min_s));

  assign max_a   = max_a_q;
  assign min_a   = min_a_q;
  assign trk_vld = trk_vld_q;

  // Tracker: first accept after reset/clr seeds both extremes with a.
  always_comb begin
    max_a_d   = max_a_q;
    min_a_d   = min_a_q;
    trk_vld_d = trk_vld_q;
    if (acc_s) begin
      trk_vld_d = 1'b1;
      if (clr || !trk_vld_q) begin
        max_a_d = a;
        min_a_d = a;
      end else begin
        max_a_d = (vs_max_s == CMP_GT) ? a : max_a_q;
        min_a_d = (vs_min_s == CMP_LT) ? a : min_a_q;
      end
    end else if (clr) begin
      max_a_d   = {DATAWIDTH{1'b0}};
      min_a_d   = {DATAWIDTH{1'b0}};
      trk_vld_d = 1'b0;
    end else begin
      trk_vld_d = trk_vld_q;
    end
  end

  // Tracker state.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      max_a_q   <= {DATAWIDTH{1'b0}};
      min_a_q   <= {DATAWIDTH{1'b0}};
      trk_vld_q <= 1'b0;
    end else begin
      max_a_q   <= max_a_d;
      min_a_q   <= min_a_d;
      trk_vld_q <= trk_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_comp.sv
// Directed + randomized scoreboard bench for pipe_comp (DATAWIDTH=8, CNTWIDTH=2);
// covers the PIPE_COMP_MINMAX_EN tracker when that macro is defined.
module tb_pipe_comp;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       clr, in_valid, in_ready, sgn, out_valid, out_ready, gt, lt, eq;
  logic [7:0] a, b;
  logic [1:0] cnt_gt, cnt_lt, cnt_eq;
`ifdef PIPE_COMP_MINMAX_EN
  logic [7:0] max_a, min_a;
  logic       trk_vld;
`endif

  int total = 0;
  int bad   = 0;

  logic [2:0] sb[$];
  logic       m_ov;
  int         m_gt, m_lt, m_eq;
  logic [7:0] m_max, m_min;
  logic       m_trk;

  pipe_comp #(.DATAWIDTH(8), .CNTWIDTH(2)) dut (
    .Clk(Clk), .Rst(Rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
    .gt(gt), .lt(lt), .eq(eq),
`ifdef PIPE_COMP_MINMAX_EN
    .max_a(max_a), .min_a(min_a), .trk_vld(trk_vld),
`endif
    .cnt_gt(cnt_gt), .cnt_lt(cnt_lt), .cnt_eq(cnt_eq)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic gtv, ltv;
    gtv = s ? ($signed(x) > $signed(y)) : (x > y);
    ltv = s ? ($signed(x) < $signed(y)) : (x < y);
    return {gtv, ltv, !(gtv || ltv)};
  endfunction

  function automatic int sat(input int v, input logic inc);
    return (inc && v < 3) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_ov = 1'b0; sb.delete();
    m_gt = 0; m_lt = 0; m_eq = 0;
    m_max = 8'h00; m_min = 8'h00; m_trk = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check pre-edge outputs, update model, check post-edge state.
  task automatic cyc(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                     input logic is, input logic ordy, input logic iclr);
    logic       rdy, acc;
    logic [2:0] r, front;
    in_valid = iv; a = ia; b = ib; sgn = is; out_ready = ordy; clr = iclr;
    #1;
    rdy   = !m_ov || ordy;
    acc   = iv && rdy;
    front = (m_ov && sb.size() > 0) ? sb[0] : 3'b000;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_ov);
    chk("flags", {gt, lt, eq}, front);
    if (m_ov && ordy && sb.size() > 0) void'(sb.pop_front());
    r = ref_cmp(ia, ib, is);
    if (acc) sb.push_back(r);
    m_ov = acc || (m_ov && !ordy);
    if (iclr) begin m_gt = 0; m_lt = 0; m_eq = 0; end
    m_gt = sat(m_gt, acc && r[2]);
    m_lt = sat(m_lt, acc && r[1]);
    m_eq = sat(m_eq, acc && r[0]);
    if (acc) begin
      if (iclr || !m_trk) begin
        m_max = ia; m_min = ia;
      end else begin
        if (ref_cmp(ia, m_max, is) == 3'b100) m_max = ia;
        if (ref_cmp(ia, m_min, is) == 3'b010) m_min = ia;
      end
      m_trk = 1'b1;
    end else if (iclr) begin
      m_max = 8'h00; m_min = 8'h00; m_trk = 1'b0;
    end
    @(posedge Clk);
    #1;
    chk("cnt_gt", cnt_gt, m_gt[1:0]);
    chk("cnt_lt", cnt_lt, m_lt[1:0]);
    chk("cnt_eq", cnt_eq, m_eq[1:0]);
`ifdef PIPE_COMP_MINMAX_EN
    chk("trk_vld", trk_vld, m_trk);
    chk("max_a", max_a, m_max);
    chk("min_a", min_a, m_min);
`endif
    @(negedge Clk);
  endtask

  initial begin
    Rst = 1'b0; clr = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; sgn = 1'b0; out_ready = 1'b1;
    model_reset();
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_flags", {gt, lt, eq}, 3'b000);
    chk("rst_cnt", {cnt_gt, cnt_lt, cnt_eq}, 6'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // Signed vs unsigned interpretation of 0x80 vs 0x01.
    cyc(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    chk("signed_lt", {gt, lt, eq}, 3'b010);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Backpressure: stall 3 cycles, then stream.
    cyc(1'b1, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h07, 8'h02, 1'b0, 1'b0, 1'b0);
    chk("stall_flags", {gt, lt, eq}, 3'b010);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(i), 8'h01, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Saturation and clr coinciding with an eq accept.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h2A, 8'h2A, 1'b0, 1'b1, 1'b0);
    chk("eq_sat", cnt_eq, 2'd3);
    cyc(1'b1, 8'h11, 8'h11, 1'b1, 1'b1, 1'b1);
    chk("clr_eq_one", {cnt_gt, cnt_lt, cnt_eq}, 6'b00_00_01);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Tracker sequence 5, -3, 7 signed, then clr.
    cyc(1'b1, 8'h05, 8'h00, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 8'hFD, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0);
`ifdef PIPE_COMP_MINMAX_EN
    chk("trk_max7", max_a, 8'h07);
    chk("trk_minFD", min_a, 8'hFD);
`endif
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
`ifdef PIPE_COMP_MINMAX_EN
    chk("trk_clr", trk_vld, 1'b0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 8'h40 : $urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));

    // Async reset in the middle of a stall.
    cyc(1'b1, 8'h09, 8'h04, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2 Rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_flags", {gt, lt, eq}, 3'b000);
    chk("mid_rst_cnt", {cnt_gt, cnt_lt, cnt_eq}, 6'd0);
`ifdef PIPE_COMP_MINMAX_EN
    chk("mid_rst_trk", {trk_vld, max_a, min_a}, 17'd0);
`endif
    @(negedge Clk);
    Rst = 1'b1;
    model_reset();
    cyc(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
